// File: rtl/alu_pkg.sv
// alu_pkg: shared constants for the ALU slice.
//   XLEN_DEFAULT - default operand/result width
//   ALU_*        - 4-bit operation codes driven on alu_unit.i_op
package alu_pkg;

   localparam int XLEN_DEFAULT = 32;

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_SLL  = 4'd2;
   localparam logic [3:0] ALU_SLT  = 4'd3;
   localparam logic [3:0] ALU_SLTU = 4'd4;
   localparam logic [3:0] ALU_XOR  = 4'd5;
   localparam logic [3:0] ALU_SRL  = 4'd6;
   localparam logic [3:0] ALU_SRA  = 4'd7;
   localparam logic [3:0] ALU_OR   = 4'd8;
   localparam logic [3:0] ALU_AND  = 4'd9;
   localparam logic [3:0] ALU_MIN  = 4'd10;
   localparam logic [3:0] ALU_MAX  = 4'd11;
   localparam logic [3:0] ALU_MINU = 4'd12;
   localparam logic [3:0] ALU_MAXU = 4'd13;
   localparam logic [3:0] ALU_ANDN = 4'd14;
   localparam logic [3:0] ALU_ORN  = 4'd15;

endpackage

// File: rtl/alu_shifter.sv
// alu_shifter: combinational barrel shifter serving SLL, SRL and SRA.
//   data_i  - value to shift
//   shamt_i - shift amount (log2(XLEN) bits)
//   left_i  - 1: shift left, 0: shift right
//   arith_i - 1: sign-fill on right shifts (ignored for left shifts)
//   data_o  - shifted result
// Left shifts reuse the right shifter by bit-reversing input and output.
module alu_shifter #(
   parameter int XLEN = 32,
   parameter int SHW  = $clog2(XLEN)
) (
   input  logic [XLEN-1:0] data_i,
   input  logic [SHW-1:0]  shamt_i,
   input  logic            left_i,
   input  logic            arith_i,
   output logic [XLEN-1:0] data_o
);

   logic [XLEN-1:0]   rev_in;
   logic [XLEN-1:0]   src;
   logic              fill;
   logic signed [XLEN:0] ext;
   logic signed [XLEN:0] ext_sh;
   logic [XLEN-1:0]   rev_out;

   always_comb begin
      rev_in = '0;
      for (int i = 0; i < XLEN; i++) rev_in[i] = data_i[XLEN-1-i];
   end

   assign src  = left_i ? rev_in : data_i;
   // Sign fill only makes sense for right shifts of the unreversed operand.
   assign fill = arith_i & ~left_i & data_i[XLEN-1];
   assign ext  = {fill, src};
   assign ext_sh = ext >>> shamt_i;

   always_comb begin
      rev_out = '0;
      for (int i = 0; i < XLEN; i++) rev_out[i] = ext_sh[XLEN-1-i];
   end

   assign data_o = left_i ? rev_out : ext_sh[XLEN-1:0];

endmodule

// File: rtl/alu_unit.sv
// alu_unit: single-cycle integer ALU with a registered result.
//   i_clk   - clock, rising edge
//   i_rst   - synchronous active-high reset (clears o_Y and o_equal)
//   i_A     - operand A
//   i_B     - operand B / shift amount source (low log2(XLEN) bits)
//   i_op    - operation select (alu_pkg::ALU_*)
//   o_Y     - result, valid one cycle after the inputs are sampled
//   o_equal - registered A==B, independent of i_op
// Build option: define ALU_UNIT_EXT_EN to enable ops 10..15
// (MIN/MAX/MINU/MAXU/ANDN/ORN); otherwise they return 0.
module alu_unit
   import alu_pkg::*;
#(
   parameter int XLEN = XLEN_DEFAULT
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic [XLEN-1:0] i_A,
   input  logic [XLEN-1:0] i_B,
   input  logic [3:0]      i_op,
   output logic [XLEN-1:0] o_Y,
   output logic            o_equal
);

   localparam int SHW = $clog2(XLEN);

   logic [XLEN-1:0] y_d, y_q;
   logic            eq_d, eq_q;
   logic [XLEN-1:0] sh_res;
   logic            lt_s, lt_u;

   assign lt_s = $signed(i_A) < $signed(i_B);
   assign lt_u = i_A < i_B;
   assign eq_d = (i_A == i_B);

   alu_shifter #(.XLEN(XLEN), .SHW(SHW)) u_shifter (
      .data_i  (i_A),
      .shamt_i (i_B[SHW-1:0]),
      .left_i  (i_op == ALU_SLL),
      .arith_i (i_op == ALU_SRA),
      .data_o  (sh_res)
   );

   always_comb begin
      y_d = '0;
      case (i_op)
         ALU_ADD:  y_d = i_A + i_B;
         ALU_SUB:  y_d = i_A - i_B;
         ALU_SLL,
         ALU_SRL,
         ALU_SRA:  y_d = sh_res;
         ALU_SLT:  y_d = {{(XLEN-1){1'b0}}, lt_s};
         ALU_SLTU: y_d = {{(XLEN-1){1'b0}}, lt_u};
         ALU_XOR:  y_d = i_A ^ i_B;
         ALU_OR:   y_d = i_A | i_B;
         ALU_AND:  y_d = i_A & i_B;
`ifdef ALU_UNIT_EXT_EN
         ALU_MIN:  y_d = lt_s ? i_A : i_B;
         ALU_MAX:  y_d = lt_s ? i_B : i_A;
         ALU_MINU: y_d = lt_u ? i_A : i_B;
         ALU_MAXU: y_d = lt_u ? i_B : i_A;
         ALU_ANDN: y_d = i_A & ~i_B;
         ALU_ORN:  y_d = i_A | ~i_B;
`endif
         default:  y_d = '0;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         y_q  <= '0;
         eq_q <= 1'b0;
      end else begin
         y_q  <= y_d;
         eq_q <= eq_d;
      end
   end

   assign o_Y     = y_q;
   assign o_equal = eq_q;

endmodule

// File: tb/tb_alu_unit.sv
// Scoreboard bench for alu_unit: the driver pushes the hand-computed
// response for every cycle it drives; the monitor pops one entry per
// rising edge and compares it against o_Y / o_equal.
module tb_alu_unit;

   typedef struct {
      logic [31:0] y;
      logic        eq;
      string       name;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] a = '0, b = '0;
   logic [3:0]  op = '0;
   logic [31:0] y;
   logic        eq;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   alu_unit #(.XLEN(32)) dut (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_A     (a),
      .i_B     (b),
      .i_op    (op),
      .o_Y     (y),
      .o_equal (eq)
   );

   task automatic issue(input logic r, input logic [31:0] va, input logic [31:0] vb,
                        input logic [3:0] vop, input logic [31:0] ey, input logic eeq,
                        input string nm);
      exp_t e;
      @(negedge clk);
      rst = r; a = va; b = vb; op = vop;
      e.y = ey; e.eq = eeq; e.name = nm;
      exp_q.push_back(e);
   endtask

   // Monitor: each rising edge registers exactly one driven cycle.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (y !== e.y) begin
               errors++;
               $display("FAIL %s o_Y got %h want %h", e.name, y, e.y);
            end
            checks++;
            if (eq !== e.eq) begin
               errors++;
               $display("FAIL %s o_equal got %b want %b", e.name, eq, e.eq);
            end
         end
      end
   end

   logic [31:0] x_min, x_max, x_minu, x_maxu, x_andn, x_orn, x_min_neg;

   initial begin
`ifdef ALU_UNIT_EXT_EN
      x_min = 32'd2; x_max = 32'd16; x_minu = 32'd2; x_maxu = 32'd16;
      x_andn = 32'd16; x_orn = 32'hFFFF_FFFD; x_min_neg = 32'hFFFF_FFFF;
`else
      x_min = 0; x_max = 0; x_minu = 0; x_maxu = 0;
      x_andn = 0; x_orn = 0; x_min_neg = 0;
`endif
      // reset holds outputs at zero even with A==B on the inputs
      issue(1, 32'd5, 32'd5, 4'd0, 32'd0, 1'b0, "rst0");
      issue(1, 32'd5, 32'd5, 4'd0, 32'd0, 1'b0, "rst1");
      // A=16, B=2 across the base ops
      issue(0, 32'd16, 32'd2, 4'd0, 32'd18, 1'b0, "add");
      issue(0, 32'd16, 32'd2, 4'd1, 32'd14, 1'b0, "sub");
      issue(0, 32'd16, 32'd2, 4'd2, 32'd64, 1'b0, "sll");
      issue(0, 32'd16, 32'd2, 4'd3, 32'd0,  1'b0, "slt");
      issue(0, 32'd16, 32'd2, 4'd4, 32'd0,  1'b0, "sltu");
      issue(0, 32'd16, 32'd2, 4'd5, 32'd18, 1'b0, "xor");
      issue(0, 32'd16, 32'd2, 4'd6, 32'd4,  1'b0, "srl");
      issue(0, 32'd16, 32'd2, 4'd7, 32'd4,  1'b0, "sra");
      issue(0, 32'd16, 32'd2, 4'd8, 32'd18, 1'b0, "or");
      issue(0, 32'd16, 32'd2, 4'd9, 32'd0,  1'b0, "and");
      // extension ops (zero when not built in)
      issue(0, 32'd16, 32'd2, 4'd10, x_min,  1'b0, "min");
      issue(0, 32'd16, 32'd2, 4'd11, x_max,  1'b0, "max");
      issue(0, 32'd16, 32'd2, 4'd12, x_minu, 1'b0, "minu");
      issue(0, 32'd16, 32'd2, 4'd13, x_maxu, 1'b0, "maxu");
      issue(0, 32'd16, 32'd2, 4'd14, x_andn, 1'b0, "andn");
      issue(0, 32'd16, 32'd2, 4'd15, x_orn,  1'b0, "orn");
      // all-ones operand: signed vs unsigned, sign fill, wrap
      issue(0, 32'hFFFF_FFFF, 32'd1, 4'd3, 32'd1, 1'b0, "slt_neg");
      issue(0, 32'hFFFF_FFFF, 32'd1, 4'd4, 32'd0, 1'b0, "sltu_big");
      issue(0, 32'hFFFF_FFFF, 32'd1, 4'd7, 32'hFFFF_FFFF, 1'b0, "sra_neg");
      issue(0, 32'hFFFF_FFFF, 32'd1, 4'd6, 32'h7FFF_FFFF, 1'b0, "srl_neg");
      issue(0, 32'hFFFF_FFFF, 32'd1, 4'd0, 32'd0, 1'b0, "add_wrap");
      issue(0, 32'hFFFF_FFFF, 32'd1, 4'd10, x_min_neg, 1'b0, "min_neg");
      issue(0, 32'd0, 32'd1, 4'd1, 32'hFFFF_FFFF, 1'b0, "sub_wrap");
      // equality flag independent of op
      issue(0, 32'h1234, 32'h1234, 4'd5, 32'd0, 1'b1, "eq_xor");
      issue(0, 32'h1234, 32'h1234, 4'd9, 32'h1234, 1'b1, "eq_and");
      issue(0, 32'h1234, 32'h1235, 4'd8, 32'h1235, 1'b0, "neq_or");
      // shift amount masked to 5 bits (33 -> 1)
      issue(0, 32'd1, 32'd33, 4'd2, 32'd2, 1'b0, "sll_mask");
      issue(0, 32'h8000_0000, 32'd33, 4'd6, 32'h4000_0000, 1'b0, "srl_mask");
      issue(0, 32'h8000_0000, 32'd33, 4'd7, 32'hC000_0000, 1'b0, "sra_mask");
      // single-cycle reset between two adds
      issue(0, 32'd3, 32'd4, 4'd0, 32'd7, 1'b0, "add_pre");
      issue(1, 32'd3, 32'd3, 4'd0, 32'd0, 1'b0, "rst_mid");
      issue(0, 32'd10, 32'd5, 4'd0, 32'd15, 1'b0, "add_post");
      issue(0, 32'd7, 32'd7, 4'd1, 32'd0, 1'b1, "sub_eq");
      repeat (3) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain pending got %0d want 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_unit.md
ALU_UNIT -- requirements
Module: alu_unit

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 Parameter XLEN, default 32, SHALL set the operand and result width in bits; the shift-amount width is log2(XLEN), i.e. 5 at the default.
REQ-003 i_clk  input  1  SHALL be the clock; all state updates on its rising edge.
REQ-004 i_rst  input  1  SHALL be the synchronous active-high reset.
REQ-005 i_A  input  XLEN  SHALL be operand A.
REQ-006 i_B  input  XLEN  SHALL be operand B, and also the shift amount source.
REQ-007 i_op  input  4  SHALL be the operation select.
REQ-008 o_Y  output  XLEN  SHALL be the registered result.
REQ-009 o_equal  output  1  SHALL be the registered A==B flag, used for branch compare.

Function
REQ-010 Latency SHALL be exactly 1 cycle: i_A, i_B and i_op are sampled at a rising edge, and o_Y and o_equal reflect them after that edge; there is no handshake and an operation is accepted every cycle.
REQ-011 i_op encoding SHALL be:
- 0 ADD: A+B, modulo 2^XLEN.
- 1 SUB: A-B, modulo 2^XLEN.
- 2 SLL: A<<B[4:0].
- 3 SLT: signed A<B gives 1, else 0.
- 4 SLTU: unsigned A<B gives 1, else 0.
- 5 XOR: A^B.
- 6 SRL: logical A>>B[4:0].
- 7 SRA: arithmetic A>>>B[4:0].
- 8 OR: A|B.
- 9 AND: A&B.
- 10..15: extension ops (REQ-016).
REQ-012 Shifts SHALL use only the low log2(XLEN) bits of B; the upper bits of B are ignored, so B=33 shifts by 1.
REQ-013 Carries and borrows SHALL be discarded; no overflow flag.
REQ-014 o_equal SHALL be 1 when A==B, independent of i_op, and 0 otherwise.
REQ-015 SLT and SLTU results SHALL be zero-extended to XLEN.

Configuration
REQ-016 Macro ALU_UNIT_EXT_EN SHALL control the extension ops:
- Defined: 10 MIN (signed), 11 MAX (signed), 12 MINU, 13 MAXU, 14 ANDN (A&~B), 15 ORN (A|~B).
- Undefined: ops 10..15 SHALL yield o_Y=0, and o_equal SHALL still be computed.

Reset
REQ-017 While i_rst=1 at a rising edge, o_Y SHALL load 0 and o_equal SHALL load 0, regardless of the inputs.
REQ-018 Reset SHALL take priority over any operation, including when asserted mid-stream.
REQ-019 The first edge with i_rst=0 SHALL register the current inputs normally.
REQ-020 Outputs before the first reset edge are undefined.

Structure
REQ-021 Package alu_pkg SHALL hold the 4-bit op-code constants (ALU_ADD … ALU_ORN) and the XLEN default.
REQ-022 A sub-module alu_shifter SHALL implement SLL, SRL and SRA as one barrel shifter (inputs: data, shamt, direction, arithmetic); alu_unit instantiates it.
REQ-023 All other logic in alu_unit SHALL be combinational result selection feeding a single output register stage.

Verification
REQ-024 Reset then A=16, B=2, ops 0..9 in successive cycles SHALL give o_Y, one cycle later, of 18, 14, 64, 0, 0, 18, 4, 4, 18, 0 respectively, with o_equal=0.
REQ-025 With ALU_UNIT_EXT_EN defined, A=16, B=2, ops 10..15 SHALL give 2, 16, 2, 16, 16, 0xFFFFFFFD; with the macro undefined, the same stimulus SHALL give 0 for all six.
REQ-026 A=0xFFFFFFFF, B=1:
- SLT SHALL give 1 and SLTU SHALL give 0.
- SRA SHALL give 0xFFFFFFFF and SRL SHALL give 0x7FFFFFFF.
- ADD SHALL give 0 (wrap).
REQ-027 A=B=0x1234, any op, SHALL give o_equal=1 after one cycle; then changing B to 0x1235 SHALL give o_equal=0 on the next cycle.
REQ-028 A=1, B=33, SLL SHALL give 2 (shamt masked).
REQ-029 Asserting i_rst for one cycle between two ADD operations SHALL give o_Y=0 and o_equal=0 for exactly that cycle, with normal results resuming on the following cycle.
